// File: rtl/rr_sel4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_sel4
//  Purpose  : Round-robin 2-bit select generator for a 4:1 mux. Each grant is
//             held for at most DWELL cycles. Optional build macro RR_LOCK_EN
//             adds a lock input that holds the current grant past its dwell.
//  Revision : 1.0  initial release
// ============================================================================
module rr_sel4 #(
    parameter int DWELL = 4,
    parameter int CW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
`ifdef RR_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] s,
    output logic       gnt_valid,
    output logic [3:0] gnt_onehot,
    output logic       busy
);

    localparam logic [CW-1:0] C_CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [1:0]      r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_s;
    logic            r_gnt_valid;
    logic [3:0]      r_gnt_onehot;

    logic            w_lock;
    logic            w_expire;
    logic            w_release;
    logic [1:0]      w_ptr_next;
    logic [2:0]      w_pick_idle;
    logic [2:0]      w_pick_next;

    // {found, index}: first requester at or after p, wrapping mod 4.
    function automatic logic [2:0] pick(input logic [1:0] p, input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        for (int j = 3; j >= 0; j--) begin
            c = p + 2'(j);
            if (r[c]) res = {1'b1, c};
        end
        return res;
    endfunction

`ifdef RR_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    always_comb begin
        w_expire    = (r_cnt == C_CNT_LAST) && !w_lock;
        w_release   = w_expire || done || !req[r_s];
        w_ptr_next  = r_s + 2'd1;
        w_pick_idle = pick(r_ptr, req);
        w_pick_next = pick(w_ptr_next, req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= 2'd0;
            r_cnt        <= '0;
            r_s          <= 2'd0;
            r_gnt_valid  <= 1'b0;
            r_gnt_onehot <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_idle[2]) begin
                        r_s          <= w_pick_idle[1:0];
                        r_gnt_onehot <= 4'b0001 << w_pick_idle[1:0];
                        r_gnt_valid  <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!w_release) begin
                        // Saturation only matters while lock masks expiry.
                        if (r_cnt != C_CNT_LAST) r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_ptr <= w_ptr_next;
                        if (w_pick_next[2]) begin
                            r_s          <= w_pick_next[1:0];
                            r_gnt_onehot <= 4'b0001 << w_pick_next[1:0];
                            r_cnt        <= '0;
                        end else begin
                            r_gnt_valid  <= 1'b0;
                            r_gnt_onehot <= 4'b0000;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s          = r_s;
    assign gnt_valid  = r_gnt_valid;
    assign gnt_onehot = r_gnt_onehot;
    assign busy       = r_gnt_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_sel4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_sel4
//  Purpose  : Directed self-checking bench for rr_sel4 with DWELL=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_sel4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
`ifdef RR_LOCK_EN
    logic       lock;
`endif
    logic [1:0] s;
    logic       gnt_valid;
    logic [3:0] gnt_onehot;
    logic       busy;

    int checks;
    int failures;

    rr_sel4 #(.DWELL(4), .CW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
`ifdef RR_LOCK_EN
        .lock       (lock),
`endif
        .s          (s),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {s, gnt_valid, gnt_onehot, busy}.
    function automatic logic [7:0] outs_for(input logic [1:0] sel, input logic v);
        return {sel, v, (v ? (4'b0001 << sel) : 4'b0000), v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
`ifdef RR_LOCK_EN
        lock = 1'b0;
`endif
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
`ifdef RR_LOCK_EN
        lock = 1'b0;
`endif
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if ({s, gnt_valid, gnt_onehot, busy} !== 8'h00) begin
                failures++;
                $display("FAIL reset cyc%0d: got %b want %b", n, {s, gnt_valid, gnt_onehot, busy}, 8'h00);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if ({s, gnt_valid, gnt_onehot, busy} !== outs_for(2'd0, 1'b1)) begin
                failures++;
                $display("FAIL single cyc%0d: got %b want %b", n, {s, gnt_valid, gnt_onehot, busy}, outs_for(2'd0, 1'b1));
            end
        end
    endtask

    task automatic test_rotate();
        logic [1:0] es;
        do_reset();
        req = 4'b1111;
        for (int n = 1; n <= 20; n++) begin
            tick();
            es = 2'(((n - 1) / 4) % 4);
            checks++;
            if ({s, gnt_valid, gnt_onehot, busy} !== outs_for(es, 1'b1)) begin
                failures++;
                $display("FAIL rotate cyc%0d: got %b want %b", n, {s, gnt_valid, gnt_onehot, busy}, outs_for(es, 1'b1));
            end
        end
    endtask

    task automatic test_done_expiry();
        do_reset();
        req = 4'b1111;
        repeat (4) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (s !== 2'd1) begin
            failures++;
            $display("FAIL done_expiry_first: got s=%0d want s=1", s);
        end
        repeat (3) tick();
        checks++;
        if (s !== 2'd1) begin
            failures++;
            $display("FAIL done_expiry_hold: got s=%0d want s=1", s);
        end
        tick();
        checks++;
        if (s !== 2'd2) begin
            failures++;
            $display("FAIL done_expiry_next: got s=%0d want s=2", s);
        end
    endtask

    task automatic test_done();
        do_reset();
        req = 4'b0101;
        tick();
        checks++;
        if ({s, gnt_valid, gnt_onehot, busy} !== outs_for(2'd0, 1'b1)) begin
            failures++;
            $display("FAIL done_grant0: got %b want %b", {s, gnt_valid, gnt_onehot, busy}, outs_for(2'd0, 1'b1));
        end
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if ({s, gnt_valid, gnt_onehot, busy} !== outs_for(2'd2, 1'b1)) begin
                failures++;
                $display("FAIL done_ch2 cyc%0d: got %b want %b", n, {s, gnt_valid, gnt_onehot, busy}, outs_for(2'd2, 1'b1));
            end
            if (n < 3) tick();
        end
        tick();
        checks++;
        if ({s, gnt_valid, gnt_onehot, busy} !== outs_for(2'd0, 1'b1)) begin
            failures++;
            $display("FAIL done_back_ch0: got %b want %b", {s, gnt_valid, gnt_onehot, busy}, outs_for(2'd0, 1'b1));
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b0100;
        repeat (3) tick();
        req = 4'b0000;
        tick();
        checks++;
        if ({s, gnt_valid, gnt_onehot, busy} !== {2'd2, 1'b0, 4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL drop_release: got %b want %b", {s, gnt_valid, gnt_onehot, busy}, {2'd2, 1'b0, 4'b0000, 1'b0});
        end
        repeat (2) tick();
        checks++;
        if ({s, gnt_valid, gnt_onehot, busy} !== {2'd2, 1'b0, 4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL drop_idle_hold: got %b want %b", {s, gnt_valid, gnt_onehot, busy}, {2'd2, 1'b0, 4'b0000, 1'b0});
        end
        req = 4'b0001;
        tick();
        checks++;
        if ({s, gnt_valid, gnt_onehot, busy} !== outs_for(2'd0, 1'b1)) begin
            failures++;
            $display("FAIL drop_wrap_ch0: got %b want %b", {s, gnt_valid, gnt_onehot, busy}, outs_for(2'd0, 1'b1));
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        req = 4'b1111;
        repeat (5) tick();
        checks++;
        if (s !== 2'd1) begin
            failures++;
            $display("FAIL rst_mid_setup: got s=%0d want s=1", s);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({s, gnt_valid, gnt_onehot, busy} !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_clear: got %b want %b", {s, gnt_valid, gnt_onehot, busy}, 8'h00);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({s, gnt_valid, gnt_onehot, busy} !== outs_for(2'd0, 1'b1)) begin
            failures++;
            $display("FAIL rst_mid_regrant: got %b want %b", {s, gnt_valid, gnt_onehot, busy}, outs_for(2'd0, 1'b1));
        end
    endtask

`ifdef RR_LOCK_EN
    task automatic test_lock();
        do_reset();
        req = 4'b1111;
        tick();
        lock = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if ({s, gnt_valid, gnt_onehot, busy} !== outs_for(2'd0, 1'b1)) begin
                failures++;
                $display("FAIL lock_hold cyc%0d: got %b want %b", n, {s, gnt_valid, gnt_onehot, busy}, outs_for(2'd0, 1'b1));
            end
        end
        lock = 1'b0;
        tick();
        checks++;
        if (s !== 2'd1) begin
            failures++;
            $display("FAIL lock_release: got s=%0d want s=1", s);
        end
        lock = 1'b1;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        lock = 1'b0;
        checks++;
        if (s !== 2'd2) begin
            failures++;
            $display("FAIL lock_done: got s=%0d want s=2", s);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        done     = 1'b0;
`ifdef RR_LOCK_EN
        lock     = 1'b0;
`endif
        test_reset();
        test_single();
        test_rotate();
        test_done_expiry();
        test_done();
        test_drop();
        test_rst_mid();
`ifdef RR_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_sel4.md
Name: rr_sel4

Overview:
Round-robin select generator that sits directly upstream of the team's 1-bit 4:1 mux and drives its 2-bit select.
- Four channel requesters raise req[i].
- The block grants one channel at a time for a bounded dwell period and drives s[1:0] for that channel.
- gnt_valid qualifies the mux output as meaningful.
- Fairness comes from a rotating priority pointer.

Parameters:
- DWELL, 4: maximum cycles one grant is held; legal range 1..2^CW.
- CW, 3: dwell counter width; 2^CW >= DWELL is required.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  4  per-channel request; bit i requests channel i.
- done  input  1  early release of the current grant; ignored when gnt_valid=0.
- s  output  2  select index to the downstream mux; registered.
- gnt_valid  output  1  a grant is active; registered.
- gnt_onehot  output  4  one-hot of s when gnt_valid=1, else 0000; registered.
- busy  output  1  high in GRANT state (equals gnt_valid; kept for the status bus).

Behaviour:
- Reset, applied at the clk edge while rst=1: state=IDLE, ptr=0, cnt=0, s=00, gnt_valid=0, gnt_onehot=0000, busy=0.
  - rst has priority over every other input.
  - rst asserted mid-grant terminates the grant at that edge.
- States: IDLE, GRANT.
- Arbitration function pick(ptr, req):
  - Returns the first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - Returns none if req=0000.
- IDLE:
  - At an edge where pick() returns channel k: s<=k, gnt_onehot<=1<<k, gnt_valid<=1, cnt<=0, state<=GRANT.
  - Latency is 1 cycle from req sampled to gnt_valid high.
  - Otherwise stay in IDLE. s holds its last value so the mux stays stable.
- GRANT: release is true at an edge if any of the following hold:
  - cnt==DWELL-1;
  - done=1;
  - req[s]=0.
- GRANT, not releasing: cnt<=cnt+1; s and gnt_valid unchanged.
- GRANT, releasing:
  - ptr_next=(s+1) mod 4, using 2-bit wrap: 11 -> 00.
  - ptr<=ptr_next.
  - If pick(ptr_next, req) returns k: load the new grant in the same edge (s<=k, gnt_onehot updated, cnt<=0, stay in GRANT). Back-to-back grants have no idle bubble, and gnt_valid stays 1.
  - Otherwise: gnt_valid<=0, gnt_onehot<=0000, state<=IDLE, s held.
- A single requester re-wins after its own release because the search wraps back to it. Its grant is reloaded with cnt=0.
- With DWELL=1, every grant lasts exactly one cycle.
- done together with expiry counts as a single release.
- Changes to req bits other than req[s] never disturb an active grant.
- All outputs are registered. No combinational path runs from input to output.

Optional Feature:
- Macro: RR_LOCK_EN.
- When defined:
  - An extra input port lock (1 bit) is added after done.
  - While lock=1 in GRANT, the dwell-expiry release term is masked; cnt saturates at DWELL-1.
  - done and a dropped req[s] still release.
  - Lock has no effect in IDLE.
- When undefined:
  - The port is absent.
  - Dwell expiry always releases.

Test Plan (DWELL=4):
1. rst=1 for 2 cycles with req=1111 -> s=00, gnt_valid=0, gnt_onehot=0000, busy=0 throughout.
2. req=0001 held from cycle 0 after reset -> gnt_valid=1, s=00 from cycle 1 onward. gnt_valid never drops. cnt resets every 4 cycles (re-grant to channel 0).
3. req=1111 held -> s sequence 00,01,10,11,00, each held exactly 4 cycles. gnt_onehot is 0001,0010,0100,1000,0001.
4. req=0101, done pulsed in the 2nd cycle of the channel-0 grant -> next cycle s=10, gnt_onehot=0100. After its 4 cycles, s=00.
5. Channel 2 granted, then req drops to 0000 in grant cycle 3 -> next cycle gnt_valid=0, gnt_onehot=0000, s stays 10. A later req=0001 gives s=00 one cycle after it is sampled (ptr=3 wraps).
6. rst pulsed during grant cycle 2 of channel 1 -> next cycle all outputs at reset values. With req=1111 after reset, the first grant is s=00.
7. RR_LOCK_EN build: req=1111, lock=1 for 10 cycles during the channel-0 grant -> s=00 holds 10+ cycles. The grant releases at the first edge after lock falls, since cnt is saturated. A done pulse under lock releases immediately.
